// File: rtl/bru_resolve_unit_pkg.sv
// Shared types and constants for the branch resolution unit and its lanes.
package bru_resolve_unit_pkg;

    // Kind of control transfer, as reported to the branch predictor.
    typedef enum logic [2:0] {
        BT_NONE   = 3'd0,
        BT_BRANCH = 3'd1,
        BT_JUMP   = 3'd2,
        BT_CALL   = 3'd3,
        BT_RETURN = 3'd4
    } BranchType_E;

    // Branch-unit opcodes carried by each issued instruction.
    localparam logic [4:0] NONE_BRU   = 5'd0;
    localparam logic [4:0] PC4_BRU    = 5'd1;
    localparam logic [4:0] ERET_BRU   = 5'd2;
    localparam logic [4:0] J_BRU      = 5'd3;
    localparam logic [4:0] JAL_BRU    = 5'd4;
    localparam logic [4:0] JR_BRU     = 5'd5;
    localparam logic [4:0] JALR_BRU   = 5'd6;
    localparam logic [4:0] BEQ_BRU    = 5'd7;
    localparam logic [4:0] BNE_BRU    = 5'd8;
    localparam logic [4:0] BLEZ_BRU   = 5'd9;
    localparam logic [4:0] BGTZ_BRU   = 5'd10;
    localparam logic [4:0] BLTZ_BRU   = 5'd11;
    localparam logic [4:0] BGEZ_BRU   = 5'd12;
    localparam logic [4:0] BLTZAL_BRU = 5'd13;
    localparam logic [4:0] BGEZAL_BRU = 5'd14;

    // Register-write timing tags for the hazard unit.
    localparam logic [1:0] NOT_WRITE = 2'd0;
    localparam logic [1:0] BRU_GEN   = 2'd1;

    // One issued instruction as seen by the branch unit.
    // imm holds the 26-bit jump index; conditional branches use imm[15:0].
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  op;
        logic        likely;
        logic [4:0]  rs_addr;
        logic [4:0]  rd_addr;
        logic [25:0] imm;
    } instr_info;

    // Link-register write produced by call instructions.
    typedef struct packed {
        logic [1:0]  tnew;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_reg_info;

    // Resolved-branch record sent to the predictor update port.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        true_branch;
        logic        mispred;
        BranchType_E branch_type;
    } bru_info;

endpackage

// File: rtl/bru_resolve_unit_lane.sv
// Combinational evaluation of one issue lane: condition, target, next PC,
// link write, branch type and mispredict against the prediction.
module bru_lane
    import bru_resolve_unit_pkg::*;
(
    input  instr_info   instr,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        pred_taken,
    input  logic [31:0] pred_target,
    output logic        is_branch,
    output logic        mispred,
    output logic        likely_nt,
    output logic [31:0] true_pc,
    output bru_info     record,
    output wr_reg_info  wr_reg
);

    logic signed [31:0] rs_s;
    logic [31:0] pc4;
    logic [31:0] pc8;
    logic [31:0] jtarget;
    logic [31:0] btarget;
    logic [31:0] target;
    logic        taken;
    logic        is_jump;
    logic        is_cond;
    logic        is_link;
    logic        is_ret;
    logic [4:0]  link_addr;
    BranchType_E btype;

    assign rs_s    = rs;
    assign pc4     = instr.pc + 32'd4;
    assign pc8     = instr.pc + 32'd8;
    assign jtarget = {instr.pc[31:28], instr.imm, 2'b00};
    assign btarget = pc4 + {{14{instr.imm[15]}}, instr.imm[15:0], 2'b00};

    // Decode the opcode into direction, target and link behaviour.
    always_comb begin
        taken     = 1'b0;
        target    = pc4;
        is_jump   = 1'b0;
        is_cond   = 1'b0;
        is_link   = 1'b0;
        is_ret    = 1'b0;
        link_addr = 5'd31;
        case (instr.op)
            J_BRU:      begin is_jump = 1'b1; taken = 1'b1; target = jtarget; end
            JAL_BRU:    begin is_jump = 1'b1; taken = 1'b1; target = jtarget; is_link = 1'b1; end
            JR_BRU:     begin is_jump = 1'b1; taken = 1'b1; target = rs;
                              is_ret = (instr.rs_addr == 5'd31); end
            JALR_BRU:   begin is_jump = 1'b1; taken = 1'b1; target = rs; is_link = 1'b1;
                              link_addr = instr.rd_addr; end
            BEQ_BRU:    begin is_cond = 1'b1; taken = (rs == rt);        target = btarget; end
            BNE_BRU:    begin is_cond = 1'b1; taken = (rs != rt);        target = btarget; end
            BLEZ_BRU:   begin is_cond = 1'b1; taken = (rs_s <= 32'sd0);  target = btarget; end
            BGTZ_BRU:   begin is_cond = 1'b1; taken = (rs_s > 32'sd0);   target = btarget; end
            BLTZ_BRU:   begin is_cond = 1'b1; taken = (rs_s < 32'sd0);   target = btarget; end
            BGEZ_BRU:   begin is_cond = 1'b1; taken = (rs_s >= 32'sd0);  target = btarget; end
            BLTZAL_BRU: begin is_cond = 1'b1; taken = (rs_s < 32'sd0);   target = btarget;
                              is_link = 1'b1; end
            BGEZAL_BRU: begin is_cond = 1'b1; taken = (rs_s >= 32'sd0);  target = btarget;
                              is_link = 1'b1; end
            default:    begin end
        endcase
    end

    // Resolve the real next PC and classify the transfer.
    always_comb begin
        // A taken branch to its own delay slot continues after the slot.
        if (taken)
            true_pc = (target == pc4) ? pc8 : target;
        else if (is_cond)
            true_pc = pc8;
        else
            true_pc = pc4;

        if (is_link)
            btype = BT_CALL;
        else if (is_ret)
            btype = BT_RETURN;
        else if (is_jump)
            btype = BT_JUMP;
        else if (is_cond)
            btype = BT_BRANCH;
        else
            btype = BT_NONE;
    end

    assign is_branch = instr.valid && (is_jump || is_cond);
    assign mispred   = is_branch &&
                       ((taken != pred_taken) || (taken && (true_pc != pred_target)));
    assign likely_nt = instr.valid && instr.likely && is_cond && !taken;

    assign record.pc          = instr.pc;
    assign record.target      = target;
    assign record.true_branch = taken;
    assign record.mispred     = mispred;
    assign record.branch_type = btype;

    // Link writes return to the instruction after the delay slot.
    assign wr_reg.tnew = (instr.valid && is_link) ? BRU_GEN : NOT_WRITE;
    assign wr_reg.addr = (instr.valid && is_link) ? link_addr : 5'd0;
    assign wr_reg.data = (instr.valid && is_link) ? pc8 : 32'd0;

endmodule

// File: rtl/bru_resolve_unit.sv
// Multi-lane branch resolution stage: oldest-mispredict redirect, squash
// beyond the delay slot, multi-write update FIFO and performance counters.
module bru_resolve_unit
    import bru_resolve_unit_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  instr_info [NUM_CH-1:0]   in_instr,
    input  logic [NUM_CH-1:0][31:0]  in_rs,
    input  logic [NUM_CH-1:0][31:0]  in_rt,
    input  logic [NUM_CH-1:0]        pred_taken,
    input  logic [NUM_CH-1:0][31:0]  pred_target,
    input  logic                     stall,
    input  logic                     flush,
    output logic                     in_ready,
    output wr_reg_info [NUM_CH-1:0]  wr_reg,
    output logic                     redirect_valid,
    output logic [31:0]              redirect_pc,
    output logic                     likely_flush,
    output logic                     upd_valid,
    output bru_info                  upd_data,
    input  logic                     upd_ready,
    output logic [31:0]              branch_cnt,
    output logic [31:0]              mispred_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [NUM_CH-1:0] lane_br;
    logic [NUM_CH-1:0] lane_mis;
    logic [NUM_CH-1:0] lane_lnt;
    logic [NUM_CH-1:0] lane_valid;
    logic [31:0]       lane_tpc [NUM_CH];
    bru_info           lane_rec [NUM_CH];

    logic [NUM_CH-1:0] live;
    logic [NUM_CH-1:0] live_br;
    logic              has_win;
    logic [31:0]       win_pc;
    logic              likely_hit;
    logic              acc;
    logic              deq;

    logic [PTR_W-1:0]  wr_addr [NUM_CH];
    logic [CNT_W-1:0]  n_enq;

    bru_info           mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_p1;
    logic [PTR_W-1:0]  rd_ptr_p1;
    logic [CNT_W-1:0]  count_p1;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        bru_lane u_lane (
            .instr       (in_instr[g]),
            .rs          (in_rs[g]),
            .rt          (in_rt[g]),
            .pred_taken  (pred_taken[g]),
            .pred_target (pred_target[g]),
            .is_branch   (lane_br[g]),
            .mispred     (lane_mis[g]),
            .likely_nt   (lane_lnt[g]),
            .true_pc     (lane_tpc[g]),
            .record      (lane_rec[g]),
            .wr_reg      (wr_reg[g])
        );
        assign lane_valid[g] = in_instr[g].valid;
    end

    assign in_ready = ((CNT_W'(DEPTH) - count_p1) >= CNT_W'(NUM_CH));
    assign acc      = (|lane_valid) && in_ready && !stall && !flush;
    assign upd_valid = (count_p1 != '0);
    assign upd_data  = mem[rd_ptr_p1];
    assign deq       = upd_valid && upd_ready;

    // Pick the oldest mispredicting lane; keep it and its delay slot live.
    always_comb begin
        logic ds_done;
        ds_done = 1'b0;
        has_win = 1'b0;
        win_pc  = 32'd0;
        live    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            live[i] = !ds_done;
            if (has_win)
                ds_done = 1'b1;
            if (!has_win && lane_mis[i]) begin
                has_win = 1'b1;
                win_pc  = lane_tpc[i];
            end
        end
    end

    assign live_br    = live & lane_br;
    assign likely_hit = |(live & lane_lnt);

    // Pack live branch records into consecutive FIFO slots in lane order.
    always_comb begin
        n_enq = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_addr[i] = wr_ptr_p1 + n_enq[PTR_W-1:0];
            if (live_br[i])
                n_enq = n_enq + CNT_W'(1);
        end
    end

    // ---- stage p1: FIFO storage ----
    // Write record payloads; storage needs no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (acc) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (live_br[i])
                    mem[wr_addr[i]] <= lane_rec[i];
            end
        end
    end

    // Advance FIFO pointers and occupancy for enqueue and dequeue.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_p1 <= '0;
            rd_ptr_p1 <= '0;
            count_p1  <= '0;
        end else begin
            if (acc)
                wr_ptr_p1 <= wr_ptr_p1 + n_enq[PTR_W-1:0];
            if (deq)
                rd_ptr_p1 <= rd_ptr_p1 + PTR_W'(1);
            count_p1 <= count_p1 + (acc ? n_enq : CNT_W'(0)) - (deq ? CNT_W'(1) : CNT_W'(0));
        end
    end

    // Launch the one-cycle redirect and likely-nullify pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            likely_flush   <= 1'b0;
        end else begin
            redirect_valid <= acc && has_win;
            redirect_pc    <= (acc && has_win) ? win_pc : 32'd0;
            likely_flush   <= acc && likely_hit;
        end
    end

    // Count resolved branches and mispredicted groups.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt  <= 32'd0;
            mispred_cnt <= 32'd0;
        end else if (acc) begin
            branch_cnt  <= branch_cnt + 32'(n_enq);
            mispred_cnt <= mispred_cnt + (has_win ? 32'd1 : 32'd0);
        end
    end

endmodule

// File: tb/tb_bru_resolve_unit.sv
// Directed self-checking bench for bru_resolve_unit: a 2-lane/4-deep
// instance for most scenarios and a 4-lane instance for delay-slot squash.
module tb_bru_resolve_unit;
    import bru_resolve_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // 2-lane, 4-deep instance
    instr_info [1:0]   a_instr;
    logic [1:0][31:0]  a_rs, a_rt, a_ptgt;
    logic [1:0]        a_pt;
    logic              a_stall, a_flush, a_upd_ready;
    logic              a_in_ready, a_redirect_valid, a_likely_flush, a_upd_valid;
    logic [31:0]       a_redirect_pc, a_branch_cnt, a_mispred_cnt;
    wr_reg_info [1:0]  a_wr_reg;
    bru_info           a_upd_data;

    // 4-lane, 8-deep instance
    instr_info [3:0]   b_instr;
    logic [3:0][31:0]  b_rs, b_rt, b_ptgt;
    logic [3:0]        b_pt;
    logic              b_in_ready, b_redirect_valid, b_likely_flush, b_upd_valid;
    logic [31:0]       b_redirect_pc, b_branch_cnt, b_mispred_cnt;
    wr_reg_info [3:0]  b_wr_reg;
    bru_info           b_upd_data;

    bru_resolve_unit #(.NUM_CH(2), .DEPTH(4)) u_dut_a (
        .clk(clk), .rst(rst), .in_instr(a_instr), .in_rs(a_rs), .in_rt(a_rt),
        .pred_taken(a_pt), .pred_target(a_ptgt), .stall(a_stall), .flush(a_flush),
        .in_ready(a_in_ready), .wr_reg(a_wr_reg), .redirect_valid(a_redirect_valid),
        .redirect_pc(a_redirect_pc), .likely_flush(a_likely_flush),
        .upd_valid(a_upd_valid), .upd_data(a_upd_data), .upd_ready(a_upd_ready),
        .branch_cnt(a_branch_cnt), .mispred_cnt(a_mispred_cnt)
    );

    bru_resolve_unit #(.NUM_CH(4), .DEPTH(8)) u_dut_b (
        .clk(clk), .rst(rst), .in_instr(b_instr), .in_rs(b_rs), .in_rt(b_rt),
        .pred_taken(b_pt), .pred_target(b_ptgt), .stall(1'b0), .flush(1'b0),
        .in_ready(b_in_ready), .wr_reg(b_wr_reg), .redirect_valid(b_redirect_valid),
        .redirect_pc(b_redirect_pc), .likely_flush(b_likely_flush),
        .upd_valid(b_upd_valid), .upd_data(b_upd_data), .upd_ready(1'b1),
        .branch_cnt(b_branch_cnt), .mispred_cnt(b_mispred_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic instr_info mk(input logic [4:0] op, input logic [31:0] pc,
                                     input logic [25:0] imm, input logic likely);
        instr_info r;
        r = '0;
        r.valid  = 1'b1;
        r.op     = op;
        r.pc     = pc;
        r.imm    = imm;
        r.likely = likely;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_a();
        a_instr = '0; a_rs = '0; a_rt = '0; a_pt = '0; a_ptgt = '0;
        a_stall = 1'b0; a_flush = 1'b0;
    endtask

    task automatic drain_a();
        a_upd_ready = 1'b1;
        tick();
        a_upd_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_a();
        a_upd_ready = 1'b0;
        b_instr = '0; b_rs = '0; b_rt = '0; b_pt = '0; b_ptgt = '0;
        repeat (2) tick();
        rst = 1'b0;

        // Reset state
        check("rst_redirect", a_redirect_valid, 0);
        check("rst_likely", a_likely_flush, 0);
        check("rst_upd_valid", a_upd_valid, 0);
        check("rst_in_ready", a_in_ready, 1);
        check("rst_branch_cnt", a_branch_cnt, 0);
        check("rst_mispred_cnt", a_mispred_cnt, 0);

        // Lane 0 beq taken but predicted not taken
        a_instr[0] = mk(BEQ_BRU, 32'h100, 26'd4, 1'b0);
        a_rs[0] = 32'd5; a_rt[0] = 32'd5;
        tick();
        clear_a();
        check("mis_redirect", a_redirect_valid, 1);
        check("mis_redirect_pc", a_redirect_pc, 32'h114);
        check("mis_mispred_cnt", a_mispred_cnt, 1);
        check("mis_branch_cnt", a_branch_cnt, 1);
        check("mis_upd_valid", a_upd_valid, 1);
        check("mis_rec_pc", a_upd_data.pc, 32'h100);
        check("mis_rec_taken", a_upd_data.true_branch, 1);
        tick();
        check("mis_pulse_end", a_redirect_valid, 0);
        drain_a();
        check("mis_drained", a_upd_valid, 0);

        // Likely branch not taken, correctly predicted
        a_instr[0] = mk(BEQ_BRU, 32'h200, 26'd8, 1'b1);
        a_instr[1] = mk(NONE_BRU, 32'h204, 26'd0, 1'b0);
        a_rs[0] = 32'd1; a_rt[0] = 32'd2;
        tick();
        clear_a();
        check("lik_flush", a_likely_flush, 1);
        check("lik_redirect", a_redirect_valid, 0);
        check("lik_branch_cnt", a_branch_cnt, 2);
        check("lik_rec_taken", a_upd_data.true_branch, 0);
        tick();
        check("lik_pulse_end", a_likely_flush, 0);
        drain_a();

        // Flush coincident with a mispredicting group
        a_flush = 1'b1;
        a_instr[0] = mk(BEQ_BRU, 32'h300, 26'd4, 1'b0);
        a_rs[0] = 32'd9; a_rt[0] = 32'd9;
        tick();
        clear_a();
        check("fl_redirect", a_redirect_valid, 0);
        check("fl_upd_valid", a_upd_valid, 0);
        check("fl_branch_cnt", a_branch_cnt, 2);
        check("fl_mispred_cnt", a_mispred_cnt, 1);

        // Stall holds the stage
        a_stall = 1'b1;
        a_instr[0] = mk(BEQ_BRU, 32'h380, 26'd4, 1'b0);
        a_rs[0] = 32'd9; a_rt[0] = 32'd9;
        tick();
        clear_a();
        check("st_redirect", a_redirect_valid, 0);
        check("st_mispred_cnt", a_mispred_cnt, 1);

        // jal correctly predicted: link write, call type, no redirect
        a_instr[0] = mk(JAL_BRU, 32'h400, 26'h140, 1'b0);
        a_pt[0] = 1'b1; a_ptgt[0] = 32'h500;
        #1;
        check("jal_wr_addr", a_wr_reg[0].addr, 31);
        check("jal_wr_data", a_wr_reg[0].data, 32'h408);
        check("jal_wr_tnew", a_wr_reg[0].tnew, BRU_GEN);
        check("jal_lane1_tnew", a_wr_reg[1].tnew, NOT_WRITE);
        tick();
        clear_a();
        check("jal_redirect", a_redirect_valid, 0);
        check("jal_type", a_upd_data.branch_type, BT_CALL);
        check("jal_branch_cnt", a_branch_cnt, 3);
        check("jal_mispred_cnt", a_mispred_cnt, 1);
        drain_a();

        // FIFO full: two 2-branch groups fill 4 entries, third is refused
        for (int g = 0; g < 3; g++) begin
            a_instr[0] = mk(BEQ_BRU, 32'h600 + 32'(g * 16), 26'd4, 1'b0);
            a_instr[1] = mk(BEQ_BRU, 32'h604 + 32'(g * 16), 26'd4, 1'b0);
            a_rs[0] = 32'd1; a_rt[0] = 32'd2;
            a_rs[1] = 32'd1; a_rt[1] = 32'd2;
            tick();
            clear_a();
            check($sformatf("full_in_ready_%0d", g), a_in_ready, (g == 0) ? 1 : 0);
            check($sformatf("full_branch_cnt_%0d", g), a_branch_cnt, (g == 0) ? 5 : 7);
        end
        a_upd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] exp_pc;
            exp_pc = (k < 2) ? 32'h600 + 32'(k * 4) : 32'h610 + 32'((k - 2) * 4);
            check($sformatf("full_head_valid_%0d", k), a_upd_valid, 1);
            check($sformatf("full_head_pc_%0d", k), a_upd_data.pc, exp_pc);
            tick();
            check($sformatf("full_ready_after_%0d", k), a_in_ready, (k >= 1) ? 1 : 0);
        end
        a_upd_ready = 1'b0;
        check("full_empty", a_upd_valid, 0);

        // 4 lanes: lane 0 bne mispredicts, lane 3 beq beyond the slot is squashed
        b_instr[0] = mk(BNE_BRU, 32'h700, 26'd4, 1'b0);
        b_rs[0] = 32'd3; b_rt[0] = 32'd3;
        b_pt[0] = 1'b1; b_ptgt[0] = 32'h714;
        b_instr[1] = mk(NONE_BRU, 32'h704, 26'd0, 1'b0);
        b_instr[3] = mk(BEQ_BRU, 32'h70c, 26'd4, 1'b0);
        b_rs[3] = 32'd7; b_rt[3] = 32'd7;
        b_pt[3] = 1'b1; b_ptgt[3] = 32'h720;
        tick();
        b_instr = '0; b_pt = '0;
        check("sq_redirect", b_redirect_valid, 1);
        check("sq_redirect_pc", b_redirect_pc, 32'h708);
        check("sq_branch_cnt", b_branch_cnt, 1);
        check("sq_mispred_cnt", b_mispred_cnt, 1);
        check("sq_rec_pc", b_upd_data.pc, 32'h700);
        tick();
        check("sq_one_record", b_upd_valid, 0);

        // Reset mid-operation empties the FIFO and drops the pending redirect
        a_instr[0] = mk(BEQ_BRU, 32'h800, 26'd4, 1'b0);
        a_rs[0] = 32'd4; a_rt[0] = 32'd4;
        tick();
        check("mr_pre_fifo", a_upd_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_a();
        check("mr_redirect", a_redirect_valid, 0);
        check("mr_upd_valid", a_upd_valid, 0);
        check("mr_branch_cnt", a_branch_cnt, 0);
        check("mr_in_ready", a_in_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bru_resolve_unit.md
# bru_resolve_unit

Multi-lane, registered branch resolution stage for the MIPS pipeline. It evaluates up to `NUM_CH` issued instructions per cycle in program order and checks each branch against its prediction. It raises one registered redirect for the oldest mispredicting lane. Resolved-branch records are buffered in a FIFO that drains to the branch predictor over a valid/ready handshake. It sits at the end of the execute stage, between issue and the predictor update port, and keeps hit/miss performance counters.

## Interface
Parameters:
- `NUM_CH`, 2: issue lanes, in program order (lane 0 oldest).
- `DEPTH`, 8: update FIFO entries; power of two, ≥ `NUM_CH`.

Ports:
- `clk` in 1: clock. Single clock domain; reset is synchronous and active-high.
- `rst` in 1: synchronous reset, active-high.
- `in_instr` in `instr_info[NUM_CH]`: issued instructions; per-lane `.valid`.
- `in_rs`, `in_rt` in `[NUM_CH][31:0]`: forwarded operands.
- `pred_taken` in `[NUM_CH]`: per-lane predicted direction.
- `pred_target` in `[NUM_CH][31:0]`: per-lane predicted target.
- `stall` in 1: hold the stage; no group is accepted.
- `flush` in 1: kill the current group and any pending redirect.
- `in_ready` out 1: group can be accepted.
- `wr_reg` out `wr_reg_info[NUM_CH]`: link-register writes. Combinational; `Tnew=BRU_GEN` or `NOT_WRITE`.
- `redirect_valid` out 1: one-cycle mispredict redirect pulse.
- `redirect_pc` out 32: corrected fetch PC.
- `likely_flush` out 1: one-cycle pulse to nullify the delay slot of a not-taken likely branch.
- `upd_valid` out 1: FIFO head valid.
- `upd_data` out `bru_info`: FIFO head record.
- `upd_ready` in 1: predictor accepts the head.
- `branch_cnt`, `mispred_cnt` out 32: performance counters.

## Operation
- **Per-lane evaluation** (combinational, `bru_lane`):
  - Conditions: j/jr/jal/jalr are always taken; beq, bne, blez, bgtz, bltz(al), bgez(al) use the usual MIPS rules on `in_rs`/`in_rt`.
  - Targets: j uses `{pc[31:28],imm26,00}`; jr uses `in_rs`; conditional branches use `pc+4+sext(imm)<<2`.
  - `true_pc`:
    - taken: target, except a target of `pc+4` gives `pc+8`;
    - not taken, delay-slot branch: `pc+8`;
    - pc4/eret: `pc+4`.
  - `branch_type`:
    - Call: jal, jalr, bltzal, bgezal;
    - Return: jr through GPR 31;
    - Jump: other j/jr;
    - Branch: `is_branch`;
    - None: everything else.
- **Mispredict** in a lane when it is a valid branch and either `taken != pred_taken`, or `taken && true_pc != pred_target`.
- **Accept**: `acc = |in_instr.valid && in_ready && !stall && !flush`.
  - When `acc` is low, no enqueue, no redirect and no counter change.
  - Upstream holds the group while `in_ready` is 0.
- **Selection**:
  - Winner i is the lowest-index mispredicting lane.
  - Branch lanes ≤ i+1 are live; lanes > i+1 are squashed (no enqueue, no count).
  - Lane i+1 is the delay slot.
- **Enqueue**: every live valid branch lane writes one `bru_info` record, in lane order. Up to `NUM_CH` writes and 1 read per cycle.
- **Counters**:
  - `branch_cnt` increases by the number of live branch lanes.
  - `mispred_cnt` increases by 1 when a winner exists.
  - Both wrap modulo 2^32.
- **Likely branch**: a live not-taken likely branch sets `likely_flush`. It also forces a redirect to `pc+8` only if it is the winner.

## Timing
- Reset values:
  - all registered outputs 0;
  - FIFO empty, pointers 0, counters 0;
  - `upd_valid=0`, `in_ready=1`.
- Redirect and `likely_flush` are registered. They pulse for exactly one cycle, the cycle after `acc`.
- A `flush` in that following cycle does not retract a pulse already asserted. A `flush` coincident with the launching edge suppresses it.
- `in_ready = (DEPTH - count) >= NUM_CH`, computed from the registered count. A dequeue in the same cycle is not credited.
- FIFO rules:
  - Dequeue when `upd_valid && upd_ready`.
  - Enqueue and dequeue in the same cycle are both honoured.
  - Pointers are `$clog2(DEPTH)` bits and wrap naturally; count is `$clog2(DEPTH)+1` bits.
  - `upd_data` is stable while `upd_valid && !upd_ready`.
  - Records appear on `upd_valid` the cycle after enqueue; there is no fall-through.
- `flush` does not clear the FIFO. Records are of resolved branches.
- `rst` mid-operation empties the FIFO and drops a pending redirect on the next edge.

## Structure
- Shared package holds:
  - the `BranchType_E`, `bru_info`, `wr_reg_info` and `instr_info` types;
  - the `*_bru` opcode constants;
  - `BRU_GEN` and `NOT_WRITE`.
- Sub-module `bru_lane`: the combinational per-lane condition, target, `true_pc`, `wr_reg`, type and mispredict logic, instantiated `NUM_CH` times.
- The top level holds winner selection, the multi-write FIFO, the redirect register and the counters.

## Test plan
- **Lane 0 mispredict**: reset, then lane 0 `beq` at pc `0x100`, rs=rt=5, imm=4, `pred_taken=0` -> next cycle `redirect_valid=1`, `redirect_pc=0x114`; `mispred_cnt=1`; one record with `true_branch=1`.
- **Squash beyond delay slot**: `NUM_CH=4`; lane 0 `bne` mispredicts, lane 3 `beq` is valid -> one record only; `branch_cnt=1`.
- **Likely not taken**: `beql` at `0x200`, not taken, `pred_taken=0` -> `likely_flush` pulses one cycle; no redirect.
- **FIFO full**: `DEPTH=4`, `NUM_CH=2`, hold `upd_ready=0`, send two 2-branch groups -> `in_ready=0` after the second; a third group is not enqueued. Release `upd_ready` -> records drain in order and `in_ready` returns when count ≤ 2.
- **Flush with accept**: `flush=1` with a mispredicting group -> no redirect, no enqueue, counters unchanged.
- **Link write**: `jal` at `0x400` -> `wr_reg` addr=31, data=`0x408`, `branch_type=Call`; a correct prediction gives no redirect.
